riscv_lsu: RTL and testbench

Load-store unit between the single-cycle RISC-V core and the data memory. It takes the core's memory request: ALU address, store data from rs2, the funct3-encoded size, and the write enable. It issues a word-aligned, byte-enabled request/acknowledge transaction to memory and stalls the core until that transaction finishes. On loads it extracts and sign- or zero-extends the addressed byte, half or word, and it flags misaligned, illegal or timed-out accesses.

---
 rtl/riscv_lsu_if.sv | 41 ++++
 rtl/riscv_lsu.sv | 173 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_if.sv
// Core-side request/response bus and memory-side request/ack bus for the load-store unit.
// Signal names keep their direction suffixes as seen from the LSU.
interface riscv_lsu_core_if;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wd_i;
  logic        lsu_stall_o;
  logic [31:0] lsu_rd_o;
  logic        lsu_err_o;
  logic [1:0]  lsu_err_cause_o;

  modport master (
    output lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_wd_i,
    input  lsu_stall_o, lsu_rd_o, lsu_err_o, lsu_err_cause_o
  );
  modport slave (
    input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_wd_i,
    output lsu_stall_o, lsu_rd_o, lsu_err_o, lsu_err_cause_o
  );
endinterface

interface riscv_lsu_mem_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ack_i
  );
  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ack_i
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load-store unit: one outstanding word-aligned byte-enabled access, stalls the core until ack/fault/timeout.
// Stall = 1 + WAIT cycles (1 cycle for faults caught at request time); memory backpressure is the ack wait.
module riscv_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  riscv_lsu_core_if.slave  core,
  riscv_lsu_mem_if.master  mem
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic [1:0]  cause_q, cause_d;

  logic        illegal, misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode; illegal size outranks misalignment.
  always_comb begin
    illegal    = (core.lsu_size_i == 3'd3) || (core.lsu_size_i[2:1] == 2'b11) ||
                 (core.lsu_we_i && core.lsu_size_i[2]);
    misaligned = ((core.lsu_size_i[1:0] == 2'b01) && core.lsu_addr_i[0]) ||
                 ((core.lsu_size_i == 3'd2) && (core.lsu_addr_i[1:0] != 2'b00));
    case (core.lsu_size_i[1:0])
      2'b00:   begin req_be = 4'b0001 << core.lsu_addr_i[1:0]; req_wd = {4{core.lsu_wd_i[7:0]}}; end
      2'b01:   begin req_be = 4'b0011 << core.lsu_addr_i[1:0]; req_wd = {2{core.lsu_wd_i[15:0]}}; end
      default: begin req_be = 4'b1111;                         req_wd = core.lsu_wd_i; end
    endcase
  end

  always_comb begin
    ld_byte = mem.mem_rd_i[7:0];
    case (off_q)
      2'd1:    ld_byte = mem.mem_rd_i[15:8];
      2'd2:    ld_byte = mem.mem_rd_i[23:16];
      2'd3:    ld_byte = mem.mem_rd_i[31:24];
      default: ld_byte = mem.mem_rd_i[7:0];
    endcase
    ld_half = off_q[1] ? mem.mem_rd_i[31:16] : mem.mem_rd_i[15:0];
    case (size_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = mem.mem_rd_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    off_d      = off_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    err_d      = err_q;
    cause_d    = cause_q;
    case (state_q)
      S_IDLE: begin
        if (core.lsu_req_i) begin
          rd_d = 32'd0;
          if (illegal || misaligned) begin
            err_d   = 1'b1;
            cause_d = illegal ? 2'b10 : 2'b01;
            state_d = S_DONE;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = core.lsu_we_i;
            mem_be_d   = req_be;
            mem_addr_d = {core.lsu_addr_i[31:2], 2'b00};
            mem_wd_d   = req_wd;
            off_d      = core.lsu_addr_i[1:0];
            size_d     = core.lsu_size_i;
            cnt_d      = 8'd0;
            err_d      = 1'b0;
            cause_d    = 2'b00;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // An ack in the final allowed cycle still completes normally.
        if (mem.mem_ack_i) begin
          rd_d      = mem_we_q ? 32'd0 : ld_data;
          err_d     = 1'b0;
          cause_d   = 2'b00;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rd_d      = 32'd0;
          err_d     = 1'b1;
          cause_d   = 2'b11;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'd0;
      mem_addr_q <= 32'd0;
      mem_wd_q   <= 32'd0;
      off_q      <= 2'd0;
      size_q     <= 3'd0;
      cnt_q      <= 8'd0;
      rd_q       <= 32'd0;
      err_q      <= 1'b0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      off_q      <= off_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    case (state_q)
      S_IDLE:  core.lsu_stall_o = core.lsu_req_i;
      S_WAIT:  core.lsu_stall_o = 1'b1;
      default: core.lsu_stall_o = 1'b0;
    endcase
  end

  assign core.lsu_rd_o        = rd_q;
  assign core.lsu_err_o       = err_q;
  assign core.lsu_err_cause_o = cause_q;
  assign mem.mem_req_o        = mem_req_q;
  assign mem.mem_we_o         = mem_we_q;
  assign mem.mem_be_o         = mem_be_q;
  assign mem.mem_addr_o       = mem_addr_q;
  assign mem.mem_wd_o         = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with TIMEOUT_CYCLES=4; inputs change and outputs are sampled on the falling edge.
module tb_riscv_lsu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_lsu_core_if core_if ();
  riscv_lsu_mem_if  mem_if ();

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .core  (core_if),
    .mem   (mem_if)
  );

  int checks = 0;
  int errors = 0;

  int          req_cnt, stall_cnt;
  logic [31:0] cap_addr, cap_wd, res_rd;
  logic [3:0]  cap_be;
  logic        cap_we, res_err, post_req;
  logic [1:0]  res_cause;

  // Runs one access from IDLE to the cycle after DONE; ack_n = WAIT cycle that acks (0 = never).
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int ack_n);
    int  wait_n = 0;
    bit  done   = 0;
    req_cnt = 0; stall_cnt = 0;
    cap_addr = 32'hx; cap_wd = 32'hx; cap_be = 4'hx; cap_we = 1'bx;
    res_rd = 32'hx; res_err = 1'bx; res_cause = 2'bx;
    core_if.lsu_req_i = 1'b1; core_if.lsu_we_i = we; core_if.lsu_size_i = sz;
    core_if.lsu_addr_i = a;   core_if.lsu_wd_i = wd;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      mem_if.mem_ack_i = 1'b0;
      mem_if.mem_rd_i  = 32'hA5A5A5A5;
      if (mem_if.mem_req_o) begin
        wait_n++; req_cnt++;
        if (wait_n == 1) begin
          cap_addr = mem_if.mem_addr_o; cap_wd = mem_if.mem_wd_o;
          cap_be = mem_if.mem_be_o; cap_we = mem_if.mem_we_o;
        end
        if (wait_n == ack_n) begin mem_if.mem_ack_i = 1'b1; mem_if.mem_rd_i = rdata; end
      end
      #1;
      if (core_if.lsu_stall_o) stall_cnt++;
      else begin
        done = 1; res_rd = core_if.lsu_rd_o; res_err = core_if.lsu_err_o; res_cause = core_if.lsu_err_cause_o;
      end
      @(negedge clk);
    end
    post_req = mem_if.mem_req_o;
    core_if.lsu_req_i = 1'b0; mem_if.mem_ack_i = 1'b0; mem_if.mem_rd_i = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    core_if.lsu_req_i = 1'b0; core_if.lsu_we_i = 1'b0; core_if.lsu_size_i = 3'd0;
    core_if.lsu_addr_i = 32'h0; core_if.lsu_wd_i = 32'h0;
    mem_if.mem_ack_i = 1'b0; mem_if.mem_rd_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_be_o, mem_if.mem_addr_o, mem_if.mem_wd_o} !== 70'd0) begin
      errors++; $display("FAIL reset_mem_outputs: got req=%b we=%b be=%h addr=%h wd=%h, expected all 0",
                         mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_be_o, mem_if.mem_addr_o, mem_if.mem_wd_o);
    end
    checks++;
    if ({core_if.lsu_rd_o, core_if.lsu_err_o, core_if.lsu_err_cause_o, core_if.lsu_stall_o} !== 36'd0) begin
      errors++; $display("FAIL reset_core_outputs: got rd=%h err=%b cause=%b stall=%b, expected all 0",
                         core_if.lsu_rd_o, core_if.lsu_err_o, core_if.lsu_err_cause_o, core_if.lsu_stall_o);
    end
    core_if.lsu_req_i = 1'b1; #1;
    checks++;
    if (core_if.lsu_stall_o !== 1'b1) begin
      errors++; $display("FAIL idle_stall_follows_req: got %b expected 1", core_if.lsu_stall_o);
    end
    core_if.lsu_req_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    checks++;
    if ({cap_addr, cap_be, cap_wd, cap_we} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
      errors++; $display("FAIL sw_request: got addr=%h be=%b wd=%h we=%b, expected 00000100 1111 deadbeef 1",
                         cap_addr, cap_be, cap_wd, cap_we);
    end
    checks++;
    if (req_cnt !== 1 || stall_cnt !== 2) begin
      errors++; $display("FAIL sw_timing: got req_cycles=%0d stall_cycles=%0d, expected 1 and 2", req_cnt, stall_cnt);
    end
    checks++;
    if ({res_err, res_cause, res_rd} !== {1'b0, 2'b00, 32'h0}) begin
      errors++; $display("FAIL sw_done: got err=%b cause=%b rd=%h, expected 0 00 00000000", res_err, res_cause, res_rd);
    end
    #1;
    checks++;
    if (post_req !== 1'b0 || core_if.lsu_stall_o !== 1'b0) begin
      errors++; $display("FAIL done_ignores_req: got mem_req=%b stall=%b after DONE, expected 0 0",
                         post_req, core_if.lsu_stall_o);
    end
    @(negedge clk);
  endtask

  task automatic test_load_byte;
    access(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF7F01, 1);
    checks++;
    if ({cap_addr, cap_be, cap_we} !== {32'h200, 4'b1000, 1'b0}) begin
      errors++; $display("FAIL lb_request: got addr=%h be=%b we=%b, expected 00000200 1000 0", cap_addr, cap_be, cap_we);
    end
    checks++;
    if (res_rd !== 32'hFFFFFF80 || res_err !== 1'b0) begin
      errors++; $display("FAIL lb_signed: got rd=%h err=%b, expected ffffff80 0", res_rd, res_err);
    end
    access(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF7F01, 1);
    checks++;
    if (res_rd !== 32'h00000080) begin
      errors++; $display("FAIL lbu_zero: got rd=%h expected 00000080", res_rd);
    end
    access(1'b0, 3'd0, 32'h201, 32'h0, 32'h80FF7F01, 1);
    checks++;
    if (res_rd !== 32'h0000007F || cap_be !== 4'b0010) begin
      errors++; $display("FAIL lb_positive: got rd=%h be=%b expected 0000007f 0010", res_rd, cap_be);
    end
    access(1'b0, 3'd1, 32'h202, 32'h0, 32'h80FF7F01, 1);
    checks++;
    if (res_rd !== 32'hFFFF80FF || cap_be !== 4'b1100) begin
      errors++; $display("FAIL lh_signed: got rd=%h be=%b expected ffff80ff 1100", res_rd, cap_be);
    end
  endtask

  task automatic test_half_and_byte_store;
    access(1'b1, 3'd1, 32'h012, 32'h0000ABCD, 32'h0, 1);
    checks++;
    if ({cap_addr, cap_be, cap_wd} !== {32'h010, 4'b1100, 32'hABCDABCD}) begin
      errors++; $display("FAIL sh_request: got addr=%h be=%b wd=%h, expected 00000010 1100 abcdabcd", cap_addr, cap_be, cap_wd);
    end
    access(1'b0, 3'd5, 32'h012, 32'h0, 32'h1234ABCD, 1);
    checks++;
    if (res_rd !== 32'h00001234 || cap_be !== 4'b1100) begin
      errors++; $display("FAIL lhu_zero: got rd=%h be=%b expected 00001234 1100", res_rd, cap_be);
    end
    access(1'b1, 3'd0, 32'h001, 32'h12345678, 32'h0, 1);
    checks++;
    if (cap_be !== 4'b0010 || cap_wd !== 32'h78787878) begin
      errors++; $display("FAIL sb_request: got be=%b wd=%h expected 0010 78787878", cap_be, cap_wd);
    end
  endtask

  task automatic test_faults;
    access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 1);
    checks++;
    if (req_cnt !== 0 || stall_cnt !== 1 || res_err !== 1'b1 || res_cause !== 2'b01) begin
      errors++; $display("FAIL lw_misaligned: got req=%0d stall=%0d err=%b cause=%b, expected 0 1 1 01",
                         req_cnt, stall_cnt, res_err, res_cause);
    end
    access(1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 1);
    checks++;
    if (req_cnt !== 0 || res_err !== 1'b1 || res_cause !== 2'b01) begin
      errors++; $display("FAIL lh_misaligned: got req=%0d err=%b cause=%b, expected 0 1 01", req_cnt, res_err, res_cause);
    end
    access(1'b1, 3'd5, 32'h100, 32'h0, 32'h0, 1);
    checks++;
    if (req_cnt !== 0 || stall_cnt !== 1 || res_err !== 1'b1 || res_cause !== 2'b10) begin
      errors++; $display("FAIL store_size5_illegal: got req=%0d stall=%0d err=%b cause=%b, expected 0 1 1 10",
                         req_cnt, stall_cnt, res_err, res_cause);
    end
    access(1'b0, 3'd3, 32'h101, 32'h0, 32'h0, 1);
    checks++;
    if (req_cnt !== 0 || res_err !== 1'b1 || res_cause !== 2'b10) begin
      errors++; $display("FAIL size3_priority: got req=%0d err=%b cause=%b, expected 0 1 10", req_cnt, res_err, res_cause);
    end
  endtask

  task automatic test_timeout;
    access(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 0);
    checks++;
    if (req_cnt !== 4 || stall_cnt !== 5) begin
      errors++; $display("FAIL timeout_timing: got req_cycles=%0d stall_cycles=%0d, expected 4 and 5", req_cnt, stall_cnt);
    end
    checks++;
    if ({res_err, res_cause, res_rd} !== {1'b1, 2'b11, 32'h0}) begin
      errors++; $display("FAIL timeout_done: got err=%b cause=%b rd=%h, expected 1 11 00000000", res_err, res_cause, res_rd);
    end
    access(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 4);
    checks++;
    if (req_cnt !== 4 || stall_cnt !== 5 || res_err !== 1'b0 || res_rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL ack_last_wait: got req=%0d stall=%0d err=%b rd=%h, expected 4 5 0 cafef00d",
                         req_cnt, stall_cnt, res_err, res_rd);
    end
  endtask

  task automatic test_reset_mid_wait;
    core_if.lsu_req_i = 1'b1; core_if.lsu_we_i = 1'b0; core_if.lsu_size_i = 3'd2;
    core_if.lsu_addr_i = 32'h404; core_if.lsu_wd_i = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h404) begin
      errors++; $display("FAIL rst_pre_wait: got req=%b addr=%h, expected 1 00000404", mem_if.mem_req_o, mem_if.mem_addr_o);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; core_if.lsu_req_i = 1'b0;
    mem_if.mem_ack_i = 1'b1; mem_if.mem_rd_i = 32'hFFFFFFFF;
    #1;
    checks++;
    if ({mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_be_o, mem_if.mem_addr_o, mem_if.mem_wd_o,
         core_if.lsu_rd_o, core_if.lsu_err_o, core_if.lsu_err_cause_o, core_if.lsu_stall_o} !== 106'd0) begin
      errors++; $display("FAIL rst_mid_wait: got req=%b be=%b addr=%h rd=%h err=%b stall=%b, expected all 0",
                         mem_if.mem_req_o, mem_if.mem_be_o, mem_if.mem_addr_o, core_if.lsu_rd_o,
                         core_if.lsu_err_o, core_if.lsu_stall_o);
    end
    @(negedge clk);
    mem_if.mem_ack_i = 1'b0; mem_if.mem_rd_i = 32'h0;
    checks++;
    if (mem_if.mem_req_o !== 1'b0 || core_if.lsu_rd_o !== 32'h0 || core_if.lsu_stall_o !== 1'b0) begin
      errors++; $display("FAIL late_ack_ignored: got req=%b rd=%h stall=%b, expected 0 00000000 0",
                         mem_if.mem_req_o, core_if.lsu_rd_o, core_if.lsu_stall_o);
    end
    access(1'b0, 3'd2, 32'h040, 32'h0, 32'h11223344, 2);
    checks++;
    if (req_cnt !== 2 || stall_cnt !== 3 || res_rd !== 32'h11223344 || res_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_access: got req=%0d stall=%0d rd=%h err=%b, expected 2 3 11223344 0",
                         req_cnt, stall_cnt, res_rd, res_err);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store_word();
    test_load_byte();
    test_half_and_byte_store();
    test_faults();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
